// File: rtl/ms_port_arb_pkg.sv
// Shared types and field widths for the IO port arbiter and its round-robin picker.
package ms_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned SIZE_W = 4;

endpackage

// File: rtl/ms_rr_pick.sv
// Combinational round-robin picker: first requester after the last-granted line, wrapping.
module ms_rr_pick #(
    parameter int unsigned CLineCnt = 2,
    localparam int unsigned IdxW = (CLineCnt > 1) ? $clog2(CLineCnt) : 1
) (
    input  logic [CLineCnt-1:0] req,
    input  logic [IdxW-1:0]     last,
    output logic [CLineCnt-1:0] grant,
    output logic [IdxW-1:0]     idx
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    logic            found;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= CLineCnt; off++) begin
            cand = 32'(last) + off;
            if (cand >= CLineCnt) begin
                cand = cand - CLineCnt;
            end
            cand_idx = IdxW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ms_port_arb.sv
// Round-robin sequencer sharing one 16-bit IO port bus among per-core requesters,
// with busy stretching, one-cycle acknowledge and a busy watchdog.
module ms_port_arb
    import ms_port_arb_pkg::*;
#(
    parameter int unsigned      CCoreCnt = 2,
    parameter logic [CNT_W-1:0] CTimeout = 16'd1023
) (
    input  logic                         AClkH,
    input  logic                         AResetH,
    input  logic                         AClkHEn,
    input  logic [CCoreCnt*ADDR_W-1:0]   APortAddr,
    input  logic [CCoreCnt*DATA_W-1:0]   APortMosi,
    input  logic [CCoreCnt*SIZE_W-1:0]   APortWrSize,
    input  logic [CCoreCnt*SIZE_W-1:0]   APortRdSize,
    output logic [DATA_W-1:0]            APortMiso,
    output logic [CCoreCnt-1:0]          APortAck,
    output logic [ADDR_W-1:0]            AIoAddr,
    output logic [DATA_W-1:0]            AIoMosi,
    output logic [SIZE_W-1:0]            AIoWrSize,
    output logic [SIZE_W-1:0]            AIoRdSize,
    input  logic [DATA_W-1:0]            AIoMiso,
    input  logic                         AIoBusy,
    output logic                         ATimeout
);

    localparam int unsigned     IdxW    = (CCoreCnt > 1) ? $clog2(CCoreCnt) : 1;
    localparam logic [IdxW-1:0] LastRst = IdxW'(CCoreCnt - 1);

    arb_state_t          state, state_nxt;
    logic                abort;
    logic [CCoreCnt-1:0] req, pick_oh, grant_oh;
    logic [IdxW-1:0]     pick_idx, grant_idx, last_idx;
    logic [CNT_W-1:0]    busy_cnt;

    logic [ADDR_W-1:0] addr_v [CCoreCnt];
    logic [DATA_W-1:0] mosi_v [CCoreCnt];
    logic [SIZE_W-1:0] wr_v   [CCoreCnt];
    logic [SIZE_W-1:0] rd_v   [CCoreCnt];

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < CCoreCnt; i++) begin
            addr_v[i] = APortAddr[i*ADDR_W +: ADDR_W];
            mosi_v[i] = APortMosi[i*DATA_W +: DATA_W];
            wr_v[i]   = APortWrSize[i*SIZE_W +: SIZE_W];
            rd_v[i]   = APortRdSize[i*SIZE_W +: SIZE_W];
            req[i]    = |{wr_v[i], rd_v[i]};
        end
    end

    ms_rr_pick #(.CLineCnt(CCoreCnt)) u_pick (
        .req   (req),
        .last  (last_idx),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|req) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!AIoBusy) begin
                    state_nxt = ST_DONE;
                end else if ((CTimeout != '0) && (busy_cnt == CTimeout - CNT_W'(1))) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state <= ST_IDLE;
        end else if (AClkHEn) begin
            state <= state_nxt;
        end
    end

    // IO outputs are cleared on leaving ACCESS so sizes are nonzero only during the access.
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            AIoAddr   <= '0;
            AIoMosi   <= '0;
            AIoWrSize <= '0;
            AIoRdSize <= '0;
            APortAck  <= '0;
            APortMiso <= '0;
            ATimeout  <= 1'b0;
            busy_cnt  <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            last_idx  <= LastRst;
        end else if (AClkHEn) begin
            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        AIoAddr   <= addr_v[pick_idx];
                        AIoMosi   <= mosi_v[pick_idx];
                        AIoWrSize <= wr_v[pick_idx];
                        AIoRdSize <= rd_v[pick_idx];
                        grant_idx <= pick_idx;
                        grant_oh  <= pick_oh;
                        busy_cnt  <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (state_nxt == ST_DONE) begin
                        AIoAddr   <= '0;
                        AIoMosi   <= '0;
                        AIoWrSize <= '0;
                        AIoRdSize <= '0;
                        APortAck  <= grant_oh;
                        APortMiso <= abort ? '0 : AIoMiso;
                        ATimeout  <= abort;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    APortAck  <= '0;
                    APortMiso <= '0;
                    ATimeout  <= 1'b0;
                    last_idx  <= grant_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ms_port_arb.sv
// Self-checking bench for ms_port_arb: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_ms_port_arb;

    localparam int unsigned N   = 3;
    localparam logic [15:0] TMO = 16'd8;

    logic            clk = 1'b0;
    logic            rst, en;
    logic [N*16-1:0] port_addr;
    logic [N*64-1:0] port_mosi;
    logic [N*4-1:0]  port_wr, port_rd;
    logic [63:0]     port_miso;
    logic [N-1:0]    port_ack;
    logic [15:0]     io_addr;
    logic [63:0]     io_mosi, io_miso;
    logic [3:0]      io_wr, io_rd;
    logic            io_busy, tmo;

    logic [15:0] c_addr [N];
    logic [63:0] c_mosi [N];
    logic [3:0]  c_wr   [N];
    logic [3:0]  c_rd   [N];
    int          last_g;
    int          n_cmp = 0;
    int          n_bad = 0;

    ms_port_arb #(.CCoreCnt(N), .CTimeout(TMO)) dut (
        .AClkH       (clk),
        .AResetH     (rst),
        .AClkHEn     (en),
        .APortAddr   (port_addr),
        .APortMosi   (port_mosi),
        .APortWrSize (port_wr),
        .APortRdSize (port_rd),
        .APortMiso   (port_miso),
        .APortAck    (port_ack),
        .AIoAddr     (io_addr),
        .AIoMosi     (io_mosi),
        .AIoWrSize   (io_wr),
        .AIoRdSize   (io_rd),
        .AIoMiso     (io_miso),
        .AIoBusy     (io_busy),
        .ATimeout    (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < int'(N); i++) begin
            port_addr[i*16 +: 16] = c_addr[i];
            port_mosi[i*64 +: 64] = c_mosi[i];
            port_wr[i*4 +: 4]     = c_wr[i];
            port_rd[i*4 +: 4]     = c_rd[i];
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < int'(N); i++) begin
            c_addr[i] = '0; c_mosi[i] = '0; c_wr[i] = '0; c_rd[i] = '0;
        end
        drive();
    endtask

    function automatic bit pend(int i);
        return (c_wr[i] != 4'd0) || (c_rd[i] != 4'd0);
    endfunction

    // Reference arbitration rule: first pending core after the last-granted one, wrapping.
    function automatic int model_pick();
        for (int k = 1; k <= int'(N); k++) begin
            if (pend((last_g + k) % int'(N))) return (last_g + k) % int'(N);
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        return N'(1) << i;
    endfunction

    task automatic new_request(int i);
        int kind;
        kind      = int'($urandom_range(0, 2));
        c_addr[i] = 16'($urandom);
        c_mosi[i] = {$urandom, $urandom};
        c_wr[i]   = (kind != 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        c_rd[i]   = (kind != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; io_busy = 1'b0; io_miso = '0;
        clear_all();
        tick(); tick();
        n_cmp++;
        if ({port_miso, port_ack, io_addr, io_mosi, io_wr, io_rd, tmo} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: ack=%b miso=%h io_addr=%h io_wr=%h io_rd=%h tmo=%b, want all 0",
                     port_ack, port_miso, io_addr, io_wr, io_rd, tmo);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({port_ack, io_wr, io_rd, tmo} !== '0) begin
            n_bad++;
            $display("FAIL idle_no_request: ack=%b io_wr=%h io_rd=%h tmo=%b, want 0", port_ack, io_wr, io_rd, tmo);
        end
        last_g = int'(N) - 1;
    endtask

    task automatic test_contention();
        c_wr[0] = 4'd8; c_mosi[0] = 64'd1; c_addr[0] = 16'h0010;
        c_wr[1] = 4'd8; c_mosi[1] = 64'd2; c_addr[1] = 16'h0020;
        drive();
        io_busy = 1'b0;
        for (int a = 0; a < 4; a++) begin
            int e;
            e = a % 2;
            tick();
            n_cmp++;
            if ({io_mosi, io_addr, io_wr, port_ack} !== {c_mosi[e], c_addr[e], 4'd8, N'(0)}) begin
                n_bad++;
                $display("FAIL contention_io[%0d]: mosi=%h addr=%h wr=%h ack=%b, want mosi=%h addr=%h wr=8",
                         a, io_mosi, io_addr, io_wr, port_ack, c_mosi[e], c_addr[e]);
            end
            tick();
            n_cmp++;
            if ({port_ack, io_wr} !== {onehot(e), 4'd0}) begin
                n_bad++;
                $display("FAIL contention_ack[%0d]: ack=%b io_wr=%h, want ack=%b io_wr=0", a, port_ack, io_wr, onehot(e));
            end
            tick();
            last_g = e;
        end
        clear_all();
    endtask

    task automatic test_single_read();
        c_rd[0] = 4'd4; c_addr[0] = 16'h0120;
        drive();
        io_busy = 1'b0;
        tick();
        n_cmp++;
        if ({io_rd, io_wr, io_addr, port_ack} !== {4'd4, 4'd0, 16'h0120, N'(0)}) begin
            n_bad++;
            $display("FAIL read_access: rd=%h wr=%h addr=%h ack=%b, want rd=4 wr=0 addr=0120 ack=0", io_rd, io_wr, io_addr, port_ack);
        end
        io_miso = 64'hDEAD_BEEF;
        tick();
        n_cmp++;
        if ({port_ack, port_miso, io_rd} !== {N'(1), 64'hDEAD_BEEF, 4'd0}) begin
            n_bad++;
            $display("FAIL read_ack: ack=%b miso=%h io_rd=%h, want ack=001 miso=deadbeef io_rd=0", port_ack, port_miso, io_rd);
        end
        clear_all();
        tick();
        n_cmp++;
        if ({port_ack, port_miso, io_rd} !== '0) begin
            n_bad++;
            $display("FAIL read_after: ack=%b miso=%h io_rd=%h, want 0", port_ack, port_miso, io_rd);
        end
        last_g = 0;
    endtask

    task automatic test_busy_stretch();
        c_rd[2] = 4'd8; c_addr[2] = 16'h0ABC;
        drive();
        tick();
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if ({io_rd, io_addr, port_ack} !== {4'd8, 16'h0ABC, N'(0)}) begin
                n_bad++;
                $display("FAIL stretch_hold[%0d]: rd=%h addr=%h ack=%b, want rd=8 addr=0abc ack=0", c, io_rd, io_addr, port_ack);
            end
            io_busy   = (c < 5);
            io_miso   = (c < 5) ? {$urandom, $urandom} : 64'hCAFE_0000_1234_5678;
            c_addr[2] = 16'($urandom);
            drive();
            tick();
        end
        n_cmp++;
        if ({port_ack, port_miso, tmo} !== {N'(4), 64'hCAFE_0000_1234_5678, 1'b0}) begin
            n_bad++;
            $display("FAIL stretch_ack: ack=%b miso=%h tmo=%b, want ack=100 miso=cafe000012345678 tmo=0", port_ack, port_miso, tmo);
        end
        clear_all();
        io_busy = 1'b0;
        tick();
        last_g = 2;
    endtask

    task automatic test_timeout();
        c_rd[1] = 4'd2; c_addr[1] = 16'h0777;
        drive();
        io_busy = 1'b1;
        tick();
        for (int c = 0; c < int'(TMO); c++) begin
            n_cmp++;
            if ({io_rd, io_addr, port_ack, tmo} !== {4'd2, 16'h0777, N'(0), 1'b0}) begin
                n_bad++;
                $display("FAIL timeout_hold[%0d]: rd=%h addr=%h ack=%b tmo=%b, want rd=2 addr=0777 ack=0 tmo=0",
                         c, io_rd, io_addr, port_ack, tmo);
            end
            io_miso = {$urandom, $urandom};
            tick();
        end
        n_cmp++;
        if ({port_ack, port_miso, tmo, io_rd} !== {N'(2), 64'd0, 1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL timeout_abort: ack=%b miso=%h tmo=%b io_rd=%h, want ack=010 miso=0 tmo=1 io_rd=0", port_ack, port_miso, tmo, io_rd);
        end
        io_busy = 1'b0;
        tick();
        n_cmp++;
        if ({port_ack, tmo} !== '0) begin
            n_bad++;
            $display("FAIL timeout_pulse: ack=%b tmo=%b, want 0", port_ack, tmo);
        end
        tick();
        io_miso = 64'h1111;
        tick();
        n_cmp++;
        if ({port_ack, port_miso, tmo} !== {N'(2), 64'h1111, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_recover: ack=%b miso=%h tmo=%b, want ack=010 miso=1111 tmo=0", port_ack, port_miso, tmo);
        end
        clear_all();
        tick();
        last_g = 1;
    endtask

    task automatic test_clock_enable();
        c_rd[0] = 4'd1; c_addr[0] = 16'h0042;
        drive();
        io_busy = 1'b1;
        tick();
        // Disabled cycles 2..4: busy low on the first, high on the others.
        for (int c = 0; c <= 10; c++) begin
            en      = !(c >= 2 && c < 5);
            io_busy = (c != 2);
            tick();
            n_cmp++;
            if (c < 10) begin
                if ({io_rd, port_ack, tmo} !== {4'd1, N'(0), 1'b0}) begin
                    n_bad++;
                    $display("FAIL enable_hold[%0d]: rd=%h ack=%b tmo=%b, want rd=1 ack=0 tmo=0", c, io_rd, port_ack, tmo);
                end
            end else if ({io_rd, port_ack, tmo} !== {4'd0, N'(1), 1'b1}) begin
                n_bad++;
                $display("FAIL enable_abort: rd=%h ack=%b tmo=%b, want rd=0 ack=001 tmo=1", io_rd, port_ack, tmo);
            end
        end
        en = 1'b0;
        clear_all();
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({port_ack, tmo, port_miso} !== {N'(1), 1'b1, 64'd0}) begin
                n_bad++;
                $display("FAIL enable_pulse_freeze[%0d]: ack=%b tmo=%b, want ack=001 tmo=1", c, port_ack, tmo);
            end
        end
        en = 1'b1;
        io_busy = 1'b0;
        tick();
        n_cmp++;
        if ({port_ack, tmo} !== '0) begin
            n_bad++;
            $display("FAIL enable_release: ack=%b tmo=%b, want 0", port_ack, tmo);
        end
        last_g = 0;
    endtask

    task automatic test_reset_mid_access();
        c_wr[1] = 4'd3; c_addr[1] = 16'h0301; c_mosi[1] = {$urandom, $urandom};
        drive();
        io_busy = 1'b1;
        tick();
        n_cmp++;
        if ({io_addr, io_wr} !== {16'h0301, 4'd3}) begin
            n_bad++;
            $display("FAIL rstmid_grant: addr=%h wr=%h, want addr=0301 wr=3", io_addr, io_wr);
        end
        c_rd[0] = 4'd5; c_addr[0] = 16'h0500;
        drive();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({port_miso, port_ack, io_addr, io_mosi, io_wr, io_rd, tmo} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: ack=%b addr=%h wr=%h rd=%h tmo=%b, want all 0", port_ack, io_addr, io_wr, io_rd, tmo);
        end
        rst = 1'b0;
        io_busy = 1'b0;
        tick();
        n_cmp++;
        if ({io_addr, io_rd, io_wr, port_ack} !== {16'h0500, 4'd5, 4'd0, N'(0)}) begin
            n_bad++;
            $display("FAIL rstmid_core0_first: addr=%h rd=%h wr=%h ack=%b, want addr=0500 rd=5", io_addr, io_rd, io_wr, port_ack);
        end
        tick();
        n_cmp++;
        if (port_ack !== N'(1)) begin
            n_bad++;
            $display("FAIL rstmid_ack0: ack=%b, want 001", port_ack);
        end
        c_rd[0] = 4'd0;
        drive();
        tick(); tick();
        n_cmp++;
        if ({io_addr, io_wr} !== {16'h0301, 4'd3}) begin
            n_bad++;
            $display("FAIL rstmid_core1_next: addr=%h wr=%h, want addr=0301 wr=3", io_addr, io_wr);
        end
        tick();
        n_cmp++;
        if (port_ack !== N'(2)) begin
            n_bad++;
            $display("FAIL rstmid_ack1: ack=%b, want 010", port_ack);
        end
        clear_all();
        tick();
        last_g = 1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 250; t++) begin
            int          e, b, ncyc;
            bit          ab;
            logic [15:0] ea;
            logic [63:0] em, ed;
            logic [3:0]  ew, er;
            for (int i = 0; i < int'(N); i++) begin
                if (!pend(i) && ($urandom_range(0, 1) == 1)) new_request(i);
            end
            drive();
            n_cmp++;
            if ({io_wr, io_rd, port_ack, tmo} !== '0) begin
                n_bad++;
                $display("FAIL rand_idle[%0d]: wr=%h rd=%h ack=%b tmo=%b, want 0", t, io_wr, io_rd, port_ack, tmo);
            end
            e = model_pick();
            if (e < 0) begin
                tick();
                continue;
            end
            ea = c_addr[e]; em = c_mosi[e]; ew = c_wr[e]; er = c_rd[e];
            b  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
            ab = (b >= int'(TMO));
            ncyc = ab ? int'(TMO) : b + 1;
            ed = '0;
            tick();
            for (int c = 0; c < ncyc; c++) begin
                n_cmp++;
                if ({io_addr, io_mosi, io_wr, io_rd, port_ack} !== {ea, em, ew, er, N'(0)}) begin
                    n_bad++;
                    $display("FAIL rand_access[%0d.%0d]: addr=%h mosi=%h wr=%h rd=%h ack=%b, want core %0d addr=%h mosi=%h wr=%h rd=%h",
                             t, c, io_addr, io_mosi, io_wr, io_rd, port_ack, e, ea, em, ew, er);
                end
                io_busy = (c < b);
                io_miso = {$urandom, $urandom};
                if (c == b) ed = io_miso;
                c_addr[e] = 16'($urandom);
                c_mosi[e] = {$urandom, $urandom};
                for (int i = 0; i < int'(N); i++) begin
                    if (!pend(i) && ($urandom_range(0, 3) == 0)) new_request(i);
                end
                drive();
                tick();
            end
            n_cmp++;
            if ({port_ack, port_miso, tmo, io_wr, io_rd} !== {onehot(e), ab ? 64'd0 : ed, ab, 4'd0, 4'd0}) begin
                n_bad++;
                $display("FAIL rand_done[%0d]: ack=%b miso=%h tmo=%b wr=%h rd=%h, want ack=%b miso=%h tmo=%b",
                         t, port_ack, port_miso, tmo, io_wr, io_rd, onehot(e), ab ? 64'd0 : ed, ab);
            end
            last_g = e;
            if ($urandom_range(0, 2) == 0) new_request(e);
            else begin
                c_wr[e] = '0; c_rd[e] = '0;
            end
            drive();
            io_busy = 1'($urandom);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; io_busy = 1'b0; io_miso = '0;
        port_addr = '0; port_mosi = '0; port_wr = '0; port_rd = '0;
        last_g = int'(N) - 1;
        test_reset();
        test_contention();
        test_single_read();
        test_busy_stretch();
        test_timeout();
        test_clock_enable();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
